// File: rtl/par_cntr_seq_ctrl_pkg.sv
// par_cntr_seq_ctrl_pkg: shared state encoding and width defaults for the counter sequencer
package par_cntr_seq_ctrl_pkg;
   localparam int CNT_W_DEF = 4;
   localparam int REP_W_DEF = 8;
   localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;
endpackage

// File: rtl/par_cntr_rep_tracker.sv
// par_cntr_rep_tracker: counts rollovers against the latched repetition count
import par_cntr_seq_ctrl_pkg::*;
module par_cntr_rep_tracker #(
   parameter int REP_W = REP_W_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start_i,
   input  logic             roll_i,
   input  logic [REP_W-1:0] reps_i,
   output logic             last_o
);
   logic [REP_W-1:0] reps_q, rep_q;
   // one extra bit keeps rep_q+1 from wrapping when reps is all-ones
   assign last_o = ({1'b0, rep_q} + (REP_W+1)'(1)) >= {1'b0, reps_q};
   always_ff @(posedge clk) begin
      if (!rstn) begin
         reps_q <= '0;
         rep_q  <= '0;
      end else if (start_i) begin
         reps_q <= (reps_i == '0) ? REP_W'(1) : reps_i;
         rep_q  <= '0;
      end else if (roll_i) begin
         rep_q <= last_o ? '0 : rep_q + REP_W'(1);
      end
   end
endmodule

// File: rtl/par_cntr_seq_ctrl.sv
// par_cntr_seq_ctrl: drives a loadable counter through preload..max intervals,
// reloading on carry and reporting rollovers as tick/done pulses
import par_cntr_seq_ctrl_pkg::*;
module par_cntr_seq_ctrl #(
   parameter int CNT_W = CNT_W_DEF,
   parameter int REP_W = REP_W_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_preload,
   input  logic [REP_W-1:0] cfg_reps,
   input  logic             cfg_periodic,
   input  logic             abort,
   output logic             cntr_load,
   output logic             cntr_en,
   output logic [CNT_W-1:0] cntr_i,
   input  logic             cntr_carry,
   output logic             tick,
   output logic             done,
   output logic             busy
);
   state_e           state_q, state_d;
   logic [CNT_W-1:0] preload_q;
   logic             periodic_q, tick_q, done_q, last, accept, roll;
   assign accept    = cfg_valid && state_q == IDLE;
   assign roll      = state_q == RUN && cntr_carry && !abort;
   // load/en stay combinational so the reload lands in the carry cycle itself
   assign cntr_load = (state_q == LOAD && !abort) || (roll && (!last || periodic_q));
   assign cntr_en   = state_q == RUN && !cntr_carry && !abort;
   assign cntr_i    = preload_q;
   assign cfg_ready = state_q == IDLE;
   assign busy      = state_q != IDLE;
   assign tick      = tick_q;
   assign done      = done_q;
   assign state_d   = accept                          ? LOAD :
                      (state_q != IDLE && abort)      ? IDLE :
                      (state_q == LOAD)               ? RUN  :
                      (roll && last && !periodic_q)   ? IDLE : state_q;
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= IDLE;
         preload_q  <= '0;
         periodic_q <= 1'b0;
         tick_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= roll;
         done_q  <= roll && last;
         if (accept) begin
            preload_q  <= cfg_preload;
            periodic_q <= cfg_periodic;
         end
      end
   end
   par_cntr_rep_tracker #(.REP_W(REP_W)) u_reps (
      .clk    (clk),
      .rstn   (rstn),
      .start_i(accept),
      .roll_i (roll),
      .reps_i (cfg_reps),
      .last_o (last)
   );
endmodule

// File: tb/tb_par_cntr_seq_ctrl.sv
// tb_par_cntr_seq_ctrl: directed and random checks of the sequencer against a
// cycle-arithmetic model (carries at t0 + k*(16-preload)) driving a real counter model
module tb_par_cntr_seq_ctrl;
   logic       clk = 0, rstn = 0, cfg_valid = 0, cfg_periodic = 0, abort = 0;
   logic [3:0] cfg_preload = 0;
   logic [7:0] cfg_reps = 0;
   logic       cfg_ready, cntr_load, cntr_en, cntr_carry, tick, done, busy;
   logic [3:0] cntr_i;
   logic [3:0] cnt = 0;
   int n_tests = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
   int tick_rel[$], done_rel[$];
   bit m_act = 0, m_per = 0, m_tick = 0, m_done = 0, armed = 0;
   int m_t0 = 0, m_p = 16, m_reps = 1, m_pre = 0;
   bit c, fin, el, ee, nt, nd;
   int k;

   always #5 clk = ~clk;
   assign cntr_carry = &cnt;
   always @(posedge clk) cnt <= cntr_load ? cntr_i : cntr_en ? cnt + 4'd1 : cnt;

   par_cntr_seq_ctrl dut (
      .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_preload(cfg_preload), .cfg_reps(cfg_reps), .cfg_periodic(cfg_periodic),
      .abort(abort), .cntr_load(cntr_load), .cntr_en(cntr_en), .cntr_i(cntr_i),
      .cntr_carry(cntr_carry), .tick(tick), .done(done), .busy(busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      c   = m_act && cyc > m_t0 && (cyc - m_t0) % m_p == 0;
      k   = c ? (cyc - m_t0) / m_p : 0;
      fin = c && !m_per && k == m_reps;
      el  = m_act && !abort && (cyc == m_t0 || (c && !fin));
      ee  = m_act && !abort && cyc > m_t0 && !c;
      if (armed) begin
         chk("tick", tick, m_tick);
         chk("done", done, m_done);
         chk("busy", busy, m_act);
         chk("cfg_ready", cfg_ready, !m_act);
         chk("cntr_i", cntr_i, m_pre);
         chk("cntr_load", cntr_load, el);
         chk("cntr_en", cntr_en, ee);
         if (m_act && cyc > m_t0) chk("carry", cntr_carry, c);
      end
      if (tick === 1'b1) tick_rel.push_back(cyc - acc_cyc);
      if (done === 1'b1) done_rel.push_back(cyc - acc_cyc);
      nt = c && !abort;
      nd = nt && k % m_reps == 0;
      if (!rstn) begin
         m_act = 0; m_tick = 0; m_done = 0; m_pre = 0;
      end else begin
         m_tick = nt;
         m_done = nd;
         if (!m_act) begin
            if (cfg_valid) begin
               m_act = 1; m_t0 = cyc + 1; m_pre = cfg_preload; m_p = 16 - cfg_preload;
               m_reps = cfg_reps == 0 ? 1 : cfg_reps; m_per = cfg_periodic; acc_cyc = cyc;
            end
         end else if (abort || (nt && fin)) m_act = 0;
      end
      armed |= !rstn;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic offer(input int p, input int r, input bit per);
      cfg_preload = 4'(p); cfg_reps = 8'(r); cfg_periodic = per; cfg_valid = 1;
      tick_rel.delete(); done_rel.delete();
   endtask

   initial begin
      int n;
      step(3); rstn = 1; step(1);
      chk("rst_ready", cfg_ready, 1);
      // one-shot 12 x3
      offer(12, 3, 0); step(1); cfg_valid = 0;
      chk("s1_load", cntr_load, 1);
      chk("s1_en", cntr_en, 0);
      step(13);
      chk("s1_busy14", busy, 0);
      chk("s1_done14", done, 1);
      step(1);
      chk("s1_hold", cnt, 15);
      chk("s1_ntick", tick_rel.size(), 3);
      if (tick_rel.size() == 3) begin
         chk("s1_t0", tick_rel[0], 6); chk("s1_t1", tick_rel[1], 10); chk("s1_t2", tick_rel[2], 14);
      end
      chk("s1_ndone", done_rel.size(), 1);
      if (done_rel.size() == 1) chk("s1_d0", done_rel[0], 14);
      // periodic 14 x2, then abort
      offer(14, 2, 1); step(1); cfg_valid = 0; step(20);
      chk("s2_ready", cfg_ready, 0);
      chk("s2_ndone", done_rel.size(), 4);
      if (done_rel.size() > 0) chk("s2_d0", done_rel[0], 6);
      abort = 1; step(1); abort = 0;
      n = tick_rel.size(); step(5);
      chk("s2_noticks", tick_rel.size(), n);
      chk("s2_idle", cfg_ready, 1);
      // preload 15, reps 0
      offer(15, 0, 0); step(1); cfg_valid = 0; step(4);
      chk("s3_ntick", tick_rel.size(), 1);
      chk("s3_ndone", done_rel.size(), 1);
      if (tick_rel.size() == 1) chk("s3_t0", tick_rel[0], 3);
      chk("s3_busy", busy, 0);
      // abort coincident with carry
      offer(13, 4, 0); step(1); cfg_valid = 0; step(3);
      abort = 1; #1;
      chk("s4_carry", cntr_carry, 1);
      chk("s4_load", cntr_load, 0);
      chk("s4_en", cntr_en, 0);
      step(1); abort = 0;
      chk("s4_ready", cfg_ready, 1);
      chk("s4_tick", tick, 0);
      chk("s4_done", done, 0);
      // config held during RUN
      offer(3, 1, 0); step(1);
      cfg_preload = 9; cfg_reps = 2;
      step(14);
      chk("s5_old", cntr_i, 3);
      chk("s5_ready", cfg_ready, 1);
      step(1); cfg_valid = 0;
      chk("s5_new", cntr_i, 9);
      chk("s5_busy", busy, 1);
      n = 0;
      while (busy && n < 100) begin step(1); n++; end
      chk("s5_finish", n < 100, 1);
      // reset mid-run
      offer(10, 5, 1); step(1); cfg_valid = 0; step(8);
      rstn = 0; step(1);
      chk("s6_busy", busy, 0); chk("s6_load", cntr_load, 0); chk("s6_en", cntr_en, 0);
      chk("s6_i", cntr_i, 0); chk("s6_tick", tick, 0); chk("s6_done", done, 0);
      rstn = 1; step(1);
      chk("s6_ready", cfg_ready, 1);
      // random
      repeat (3000) begin
         cfg_valid    = $urandom % 4 == 0;
         cfg_preload  = 4'($urandom);
         cfg_reps     = 8'($urandom % 5);
         cfg_periodic = 1'($urandom);
         abort        = $urandom % 40 == 0;
         rstn         = $urandom % 200 != 0;
         step(1);
      end
      rstn = 1; cfg_valid = 0; abort = 1; step(1); abort = 0; step(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/par_cntr_seq_ctrl.md
Name: par_cntr_seq_ctrl

Overview:
Sequencing controller for the team's 4-bit loadable synchronous counter (ports load, cnt_en, I, count, carry).
- Accepts an interval configuration over a valid/ready handshake: preload value, repetition count, one-shot/periodic mode.
- Drives the counter's load/cnt_en/I so that it runs preload..max and reloads on every carry.
- Counts rollovers and reports them as tick and done pulses.
- Sits between firmware-facing config registers and the counter instance; it owns the counter's control inputs exclusively.

Parameters:
- CNT_W, 4, width of the controlled counter and of preload/cntr_i.
- REP_W, 8, width of the repetition count and the internal rollover counter.

Ports:
- clk, input, 1, rising-edge clock shared with the counter.
- rstn, input, 1, synchronous active-low reset.
- cfg_valid, input, 1, configuration offered.
- cfg_ready, output, 1, controller idle and accepting configuration.
- cfg_preload, input, CNT_W, counter start value.
- cfg_reps, input, REP_W, rollovers per done; 0 is treated as 1.
- cfg_periodic, input, 1, 1 = restart automatically after done; 0 = one-shot.
- abort, input, 1, stop the current sequence immediately.
- cntr_load, output, 1, to counter load.
- cntr_en, output, 1, to counter cnt_en.
- cntr_i, output, CNT_W, to counter I; equals latched preload.
- cntr_carry, input, 1, from counter carry (high when count is all-ones).
- tick, output, 1, one-cycle pulse per rollover.
- done, output, 1, one-cycle pulse after reps rollovers.
- busy, output, 1, high whenever not IDLE.

Behaviour:
- Reset: one clock and a synchronous active-low reset. The clock port is clk; the reset port is rstn, sampled on the rising edge of clk.
  - rstn=0 at an edge sets state to IDLE, clears the latched config and rep_cnt, and drives tick=0, done=0, busy=0, cntr_load=0, cntr_en=0, cntr_i=0.
  - The counter is not reset by this block; the counter has its own rstn.
- States:
  - IDLE: cfg_ready=1. cfg_valid&cfg_ready at an edge latches preload, reps (0 is stored as 1) and periodic, clears rep_cnt, and moves to LOAD.
  - LOAD: cntr_load=1, cntr_en=0 for exactly one cycle; moves to RUN.
  - RUN: cntr_en=1 while cntr_carry=0.
- cntr_load and cntr_en are combinational from state, cntr_carry and abort. This is required so that reload happens in the carry cycle itself.
- Carry in RUN (cntr_carry=1, abort=0):
  - tick pulses on the next cycle (registered).
  - If rep_cnt+1 < reps: rep_cnt++, cntr_load=1 (reload), stay in RUN.
  - Else, one-shot: done pulses on the next cycle (registered), cntr_load=0, cntr_en=0, go to IDLE. The counter holds all-ones.
  - Else, periodic: done pulses on the next cycle, rep_cnt is cleared, cntr_load=1, stay in RUN.
- Period: rollovers are 16-preload cycles apart (general form 2^CNT_W - preload). preload=all-ones gives a carry every cycle; the reload is issued continuously.
- First carry: occurs 2^CNT_W - preload cycles after the LOAD cycle.
- Abort in LOAD or RUN:
  - cntr_load=0 and cntr_en=0 in the same cycle; go to IDLE at the next edge.
  - No tick and no done, even if cntr_carry=1 in that cycle (abort wins).
  - Abort in IDLE is ignored.
- cfg_valid while busy: cfg_ready=0, so the config is ignored and must be held by the source until accepted.
- cfg_valid and abort in the same IDLE cycle: the config is accepted.
- cntr_i: equals the latched preload in all non-reset states.
- rep_cnt width: REP_W, with no overflow possible because it is cleared at reps.

Decomposition:
- Shared package: state enum (IDLE, LOAD, RUN), CNT_W/REP_W defaults, CNT_MAX constant (all-ones).
- One natural sub-module: par_cntr_rep_tracker. It holds the REP_W rollover counter, the latched reps and the terminal-compare logic.
- The FSM and output decode remain in the top level.

Test Plan:
- One-shot, preload=12, reps=3, handshake at cycle 0 → cntr_load at cycle 1; carry at cycles 5, 9 and 13; tick at cycles 6, 10 and 14; done at cycle 14; busy falls at cycle 14; counter holds 15.
- Periodic, preload=14, reps=2 → carry every 2 cycles; done every 4 cycles, indefinitely; cfg_ready stays 0; abort stops it with no further tick.
- preload=15, reps=0 (treated as 1), one-shot → carry the cycle after LOAD; exactly one tick and one done.
- Abort coincident with carry in RUN (preload=13, reps=4) → no tick and no done; cntr_load=0 and cntr_en=0 that cycle; IDLE and cfg_ready=1 next cycle.
- cfg_valid held high during RUN with different values → ignored until done; re-accepted the first IDLE cycle with the new preload.
- rstn=0 mid-RUN → next cycle all outputs are 0 and the state is IDLE; cfg_ready=1 after rstn rises.
